// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared state encoding and default widths for the FIFO read-side sequencer.
// Optional word counter lives behind FIFO_RD_CNT_EN in the top module.
package fifo_rd_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_GAP_W      = 4;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SEND      = 2'b01,
    WAIT_DONE = 2'b10,
    GAP       = 2'b11
  } state_t;

endpackage

// File: rtl/fifo_rd_gap_cnt.sv
// Loadable down-counter for the inter-word idle gap; 1-cycle load, holds at zero.
// No backpressure: load wins over dec, flags are decoded from the count register.
module fifo_rd_gap_cnt
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic [GAP_W-1:0] cnt,
  output logic             is_zero,
  output logic             is_one
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == GAP_W'(1));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read sequencer: pops one word, hands it to the UART TX via valid/busy, then idles gap_cfg cycles.
// Pop 1 cycle after enable & !r_empty & !tx_busy; holds tx_valid until tx_busy; rd_count under FIFO_RD_CNT_EN.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int GAP_W      = DEF_GAP_W
`ifdef FIFO_RD_CNT_EN
  ,
  parameter int CNT_W      = DEF_CNT_W
`endif
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [GAP_W-1:0]      gap_cfg,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rinc,
  input  logic                  tx_busy,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  ctrl_busy
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]      rd_count
`endif
);

  state_t           state;
  state_t           state_nx;
  logic             pop;
  logic             gap_load;
  logic             gap_dec;
  logic             gap_zero;
  logic             gap_one;
  logic [GAP_W-1:0] gap_cnt;
  logic             word_taken;

  assign word_taken = (state == SEND) && tx_busy;

  fifo_rd_gap_cnt #(
    .GAP_W (GAP_W)
  ) u_gap_cnt (
    .clk      (r_clk),
    .rst      (reset),
    .load     (gap_load),
    .load_val (gap_cfg),
    .dec      (gap_dec),
    .cnt      (gap_cnt),
    .is_zero  (gap_zero),
    .is_one   (gap_one)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !r_empty && !tx_busy) begin
          pop      = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (tx_busy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (gap_cfg == '0) begin
            state_nx = IDLE;
          end else begin
            gap_load = 1'b1;
            state_nx = GAP;
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        // zero is unreachable in normal flow but must never trap the FSM
        if (gap_one || gap_zero) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rinc      <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      ctrl_busy <= 1'b0;
    end else begin
      state     <= state_nx;
      rinc      <= pop;
      ctrl_busy <= (state_nx != IDLE);
      if (pop) begin
        tx_data  <= r_data;
        tx_valid <= 1'b1;
      end else if (word_taken) begin
        tx_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
    end else if (word_taken) begin
      rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural FIFO and a UART TX busy model.
// Build with FIFO_RD_CNT_EN to also check the wrapping word counter at CNT_W=4.
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] gap_cfg = 4'd0;
  logic       r_empty;
  logic [7:0] r_data;
  logic       rinc;
  logic       tx_busy;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ctrl_busy;
`ifdef FIFO_RD_CNT_EN
  logic [3:0] rd_count;
`endif

  always #5 r_clk = ~r_clk;

  fifo_rd_ctrl #(
    .DATA_WIDTH (8),
    .GAP_W      (4)
`ifdef FIFO_RD_CNT_EN
    ,
    .CNT_W      (4)
`endif
  ) dut (
    .r_clk     (r_clk),
    .reset     (reset),
    .enable    (enable),
    .gap_cfg   (gap_cfg),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .rinc      (rinc),
    .tx_busy   (tx_busy),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .ctrl_busy (ctrl_busy)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  // FIFO model: first-word fall-through, pops on rinc at the clock edge
  logic [7:0] mem [0:31];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign r_empty = (wr_ptr == rd_ptr);
  assign r_data  = mem[rd_ptr[4:0]];

  always @(posedge r_clk) begin
    if (rinc) begin
      #1;
      rd_ptr = rd_ptr + 8'd1;
    end
  end

  // TX model: accepts a valid word, stays busy for busy_len cycles
  logic       tx_busy_m = 1'b0;
  logic       tx_force = 1'b0;
  logic       tx_stall = 1'b0;
  int         busy_len = 10;
  int         busy_left = 0;
  logic [7:0] rx_mem [0:63];
  int         rx_cnt = 0;
  assign tx_busy = tx_busy_m | tx_force;

  always @(posedge r_clk) begin
    if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) begin
        #1;
        tx_busy_m = 1'b0;
      end
    end else if (tx_valid && !tx_busy && !tx_stall) begin
      rx_mem[rx_cnt] = tx_data;
      rx_cnt = rx_cnt + 1;
      busy_left = busy_len;
      #1;
      tx_busy_m = 1'b1;
    end
  end

  // Monitor: pop strobes, underflow, busy-fall to pop distance
  int   ncyc = 0;
  int   rinc_total = 0;
  int   underflow = 0;
  int   double_rinc = 0;
  int   fall_n = 0;
  logic fall_seen = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_rinc = 1'b0;
  int   gaps [0:63];
  int   ngaps = 0;

  always @(negedge r_clk) begin
    ncyc = ncyc + 1;
    if (rinc) begin
      rinc_total = rinc_total + 1;
      if (r_empty) underflow = underflow + 1;
      if (prev_rinc) double_rinc = double_rinc + 1;
      if (fall_seen && ngaps < 64) begin
        gaps[ngaps] = ncyc - fall_n;
        ngaps = ngaps + 1;
      end
    end
    if (prev_busy && !tx_busy) begin
      fall_n = ncyc;
      fall_seen = 1'b1;
    end
    prev_busy = tx_busy;
    prev_rinc = rinc;
  end

  int n_asserts = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[4:0]] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_done(input string tag, input int max);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < max) begin
      @(negedge r_clk);
      n++;
      done = !ctrl_busy && !tx_busy && !tx_valid && (r_empty || !enable);
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int base_g, base_rx, base_rinc, n, bad;

  initial begin
    // reset state
    repeat (2) @(negedge r_clk);
    check("rst_rinc", {31'd0, rinc}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_ctrl_busy", {31'd0, ctrl_busy}, 32'd0);
    reset = 1'b0;

    // single word, busy 10 cycles, pop exactly one cycle after the condition
    busy_len = 10;
    push(8'hA5);
    @(negedge r_clk);
    check("t1_pre_rinc", {31'd0, rinc}, 32'd0);
    enable = 1'b1;
    @(negedge r_clk);
    check("t1_rinc", {31'd0, rinc}, 32'd1);
    check("t1_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_data", {24'd0, tx_data}, 32'hA5);
    check("t1_ctrl_busy", {31'd0, ctrl_busy}, 32'd1);
    @(negedge r_clk);
    check("t1_rinc_pulse", {31'd0, rinc}, 32'd0);
    check("t1_valid_hold", {31'd0, tx_valid}, 32'd1);
    check("t1_data_hold", {24'd0, tx_data}, 32'hA5);
    @(negedge r_clk);
    check("t1_valid_drop", {31'd0, tx_valid}, 32'd0);
    check("t1_waitdone_busy", {31'd0, ctrl_busy}, 32'd1);
    wait_done("t1_done", 40);
    check("t1_rinc_total", rinc_total, 32'd1);
    check("t1_rx", {24'd0, rx_mem[0]}, 32'hA5);

    // four words with a 3-cycle gap: fall -> next pop is gap + 2 cycles
    busy_len = 3;
    gap_cfg = 4'd3;
    base_g = ngaps;
    base_rx = rx_cnt;
    base_rinc = rinc_total;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_done("t2_done", 200);
    check("t2_rinc_count", rinc_total - base_rinc, 32'd4);
    check("t2_rx_count", rx_cnt - base_rx, 32'd4);
    for (int i = 0; i < 4; i++) check("t2_order", {24'd0, rx_mem[base_rx+i]}, i + 1);
    for (int i = 1; i < 4; i++) check("t2_gap", gaps[base_g+i], 32'd5);

    // zero gap: next pop two cycles after busy falls
    gap_cfg = 4'd0;
    base_g = ngaps;
    base_rx = rx_cnt;
    push(8'h55); push(8'h66);
    wait_done("t2b_done", 100);
    check("t2b_gap0", gaps[base_g+1], 32'd2);
    check("t2b_rx0", {24'd0, rx_mem[base_rx]}, 32'h55);
    check("t2b_rx1", {24'd0, rx_mem[base_rx+1]}, 32'h66);

    // empty FIFO, enabled for 50 cycles
    bad = 0;
    repeat (50) begin
      @(negedge r_clk);
      if (rinc || tx_valid || ctrl_busy) bad++;
    end
    check("t3_empty_quiet", bad, 32'd0);

    // transmitter busy while idle blocks the pop
    tx_force = 1'b1;
    base_rinc = rinc_total;
    push(8'h77);
    repeat (5) @(negedge r_clk);
    check("t3b_no_pop", rinc_total - base_rinc, 32'd0);
    check("t3b_idle", {31'd0, ctrl_busy}, 32'd0);
    tx_force = 1'b0;
    wait_done("t3b_done", 50);
    check("t3b_rx", {24'd0, rx_mem[rx_cnt-1]}, 32'h77);

    // enable dropped in WAIT_DONE: current word completes, next stays queued
    base_rx = rx_cnt;
    base_rinc = rinc_total;
    push(8'h11); push(8'h22);
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge r_clk);
      n++;
    end
    check("t4_accept", {31'd0, tx_busy}, 32'd1);
    enable = 1'b0;
    repeat (30) @(negedge r_clk);
    check("t4_rx_count", rx_cnt - base_rx, 32'd1);
    check("t4_rx11", {24'd0, rx_mem[base_rx]}, 32'h11);
    check("t4_pops", rinc_total - base_rinc, 32'd1);
    check("t4_queued", {31'd0, r_empty}, 32'd0);
    check("t4_idle", {31'd0, ctrl_busy}, 32'd0);
    enable = 1'b1;
    wait_done("t4_done", 50);
    check("t4_rx22", {24'd0, rx_mem[base_rx+1]}, 32'h22);

    // asynchronous reset in SEND with the transmitter never accepting
    tx_stall = 1'b1;
    push(8'h33);
    n = 0;
    while (!rinc && n < 20) begin
      @(negedge r_clk);
      n++;
    end
    check("t5_rinc", {31'd0, rinc}, 32'd1);
    check("t5_data", {24'd0, tx_data}, 32'h33);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, tx_valid}, 32'd0);
    check("t5_async_rinc", {31'd0, rinc}, 32'd0);
    check("t5_async_busy", {31'd0, ctrl_busy}, 32'd0);
    check("t5_async_data", {24'd0, tx_data}, 32'd0);
    @(negedge r_clk);
`ifdef FIFO_RD_CNT_EN
    check("t5_cnt_rst", {28'd0, rd_count}, 32'd0);
`endif
    reset = 1'b0;
    tx_stall = 1'b0;
    base_rx = rx_cnt;
    wait_done("t5_done", 50);
    check("t5_repop", {24'd0, rx_mem[base_rx]}, 32'h33);
    check("t5_drained", {31'd0, r_empty}, 32'd1);

    // 16 more words back to back (17 since reset)
    busy_len = 1;
    base_rx = rx_cnt;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    wait_done("t6_done", 400);
    check("t6_rx_count", rx_cnt - base_rx, 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx_mem[base_rx+i] !== 8'h80 + 8'(i)) bad++;
    check("t6_order", bad, 32'd0);
`ifdef FIFO_RD_CNT_EN
    check("t6_cnt_wrap", {28'd0, rd_count}, 32'd1);
`endif

    check("no_underflow", underflow, 32'd0);
    check("rinc_single", double_rinc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side sequencer for the async FIFO, running in the read clock domain.
- Pops one word at a time when the FIFO is not empty and hands it to a serial transmitter using a valid/busy handshake.
- Inserts a programmable idle gap between words.
- Sits between the FIFO's r_empty/r_data/rinc interface and the UART TX input.

Parameters:
- DATA_WIDTH, 8, width of r_data and tx_data.
- GAP_W, 4, width of the inter-word gap configuration and counter.
- CNT_W, 16, width of the sent-word counter (only with FIFO_RD_CNT_EN).

Ports:
- r_clk  in  1  read-domain clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new pops; sampled only in IDLE.
- gap_cfg  in  GAP_W  idle cycles after each word completes; 0 means no gap.
- r_empty  in  1  FIFO empty flag, already in the r_clk domain.
- r_data  in  DATA_WIDTH  FIFO head word, valid whenever r_empty=0 (first-word fall-through).
- rinc  out  1  one-cycle pop strobe to the FIFO.
- tx_busy  in  1  transmitter busy; rises after accepting a word, falls when the word is done.
- tx_valid  out  1  word available on tx_data.
- tx_data  out  DATA_WIDTH  registered word to the transmitter.
- ctrl_busy  out  1  high in every state except IDLE.
- rd_count  out  CNT_W  words sent (only with FIFO_RD_CNT_EN).

Behaviour:
- Clock and reset: one clock, r_clk; reset is asynchronous and active-high.
- All outputs are registered.
- Reset: state=IDLE; rinc=0, tx_valid=0, tx_data=0, ctrl_busy=0, gap counter=0, rd_count=0.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
- IDLE, pop condition: enable=1, r_empty=0 and tx_busy=0.
  - At the next edge: tx_data<=r_data, rinc<=1, tx_valid<=1, state<=SEND.
  - Latency from the condition being true to rinc/tx_valid high is 1 cycle.
- SEND:
  - rinc is high only in the first SEND cycle; it is always a single-cycle pulse.
  - tx_valid stays high until tx_busy=1 is sampled; tx_data is held stable.
  - On tx_busy=1: tx_valid<=0, state<=WAIT_DONE.
- WAIT_DONE: on tx_busy=0 (falling edge observed):
  - if gap_cfg=0, state<=IDLE;
  - else load counter<=gap_cfg, state<=GAP.
- GAP:
  - counter decrements each cycle.
  - When counter=1, state<=IDLE.
  - Exactly gap_cfg cycles are spent in GAP.
- gap_cfg is sampled only at the WAIT_DONE->GAP transition.
- rinc is never asserted while r_empty=1 (no underflow).
- At most one pop per word cycle. r_empty is not re-checked until IDLE, by which point the pop has propagated.
- enable deasserted mid-word: the current word completes normally (SEND/WAIT_DONE/GAP), then the FSM rests in IDLE with no pop.
- r_empty rising during SEND/WAIT_DONE/GAP: no effect; the word already captured is delivered.
- tx_busy already high in IDLE: no pop until it is low.
- Asynchronous reset mid-word: the word is dropped, outputs clear immediately, FSM returns to IDLE.
- Throughput with gap_cfg=0: one word per (1 + SEND handshake + tx busy duration + 1) cycles.

Optional Feature:
- Macro: FIFO_RD_CNT_EN.
- Defined: rd_count port exists; it increments by 1 on each SEND->WAIT_DONE transition, wraps from 2^CNT_W-1 to 0, and resets to 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_rd_ctrl_pkg holds:
  - the state encoding constants IDLE=2'b00, SEND=2'b01, WAIT_DONE=2'b10, GAP=2'b11;
  - default widths DATA_WIDTH/GAP_W/CNT_W.
- One sub-module, fifo_rd_gap_cnt: a loadable GAP_W down-counter with load, dec and a zero/one flag.
- The FSM and datapath stay in fifo_rd_ctrl.

Test Plan:
- Reset, then FIFO holding 8'hA5, enable=1, gap_cfg=0, tx model busy for 10 cycles -> 1 cycle later rinc pulses once, tx_data=8'hA5, tx_valid high until busy; back in IDLE after busy falls; rinc total=1.
- 4 words (8'h01..8'h04), gap_cfg=3 -> words delivered in order; exactly 3 GAP cycles between tx_busy falling and the next rinc; 4 rinc pulses in total.
- FIFO empty, enable=1 for 50 cycles -> rinc=0 and tx_valid=0 throughout; ctrl_busy=0.
- enable dropped during WAIT_DONE of word 8'h11 with 8'h22 still queued -> 8'h11 completes; 8'h22 not popped until enable=1 again.
- Reset asserted in SEND with tx_busy never rising -> tx_valid, rinc and ctrl_busy go to 0 asynchronously; after release, a queued word is popped anew.
- With FIFO_RD_CNT_EN, CNT_W=4, 17 words sent -> rd_count wraps to 1; without the macro, the build has no rd_count port.
